// File: rtl/muldiv_sequencer.sv
// ============================================================================
// Module   : muldiv_sequencer
// Brief    : Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO, with ID stall
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             id_uses_hilo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             bubble
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] p_q, p_d;   // product high half / partial remainder
  logic [WIDTH-1:0] q_q, q_d;   // multiplier / quotient
  logic [WIDTH-1:0] m_q, m_d;   // multiplicand / divisor magnitude
  logic             is_div_q, is_div_d;
  logic             is_signed_q, is_signed_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             div0_q, div0_d;

  // Operand magnitudes for the issuing instruction
  logic             in_signed;
  logic             in_sign_a, in_sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign in_signed = ~op[0];
  assign in_sign_a = in_signed & operand_a[WIDTH-1];
  assign in_sign_b = in_signed & operand_b[WIDTH-1];
  assign mag_a     = in_sign_a ? (~operand_a + 1'b1) : operand_a;
  assign mag_b     = in_sign_b ? (~operand_b + 1'b1) : operand_b;

  // Shift-add multiply step
  logic [WIDTH:0]   mul_sum;
  assign mul_sum = {1'b0, p_q} + (q_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});

  // Restoring divide step; the shifted remainder needs one extra bit
  logic [WIDTH:0]   div_rem_sh;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  assign div_rem_sh = {p_q, q_q[WIDTH-1]};
  assign div_diff   = div_rem_sh - {1'b0, m_q};
  assign div_ge     = (div_rem_sh >= {1'b0, m_q});

  // Sign correction of the finished magnitudes
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  assign prod_raw = {p_q, q_q};
  assign prod_fix = (is_signed_q & (sign_a_q ^ sign_b_q)) ? (~prod_raw + 1'b1) : prod_raw;
  assign quot_fix = (is_signed_q & (sign_a_q ^ sign_b_q)) ? (~q_q + 1'b1) : q_q;
  assign rem_fix  = (is_signed_q & sign_a_q) ? (~p_q + 1'b1) : p_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    p_d         = p_q;
    q_d         = q_q;
    m_d         = m_q;
    is_div_d    = is_div_q;
    is_signed_d = is_signed_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    div0_d      = div0_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          is_div_d    = op[1];
          is_signed_d = in_signed;
          sign_a_d    = in_sign_a;
          sign_b_d    = in_sign_b;
          cnt_d       = '0;
          p_d         = '0;
          if (op[1] && (operand_b == '0)) begin
            div0_d  = 1'b1;
            p_d     = operand_a;
            q_d     = '0;
            state_d = SIGN;
          end else begin
            div0_d  = 1'b0;
            state_d = CALC;
            if (op[1]) begin
              q_d = mag_a;
              m_d = mag_b;
            end else begin
              q_d = mag_b;
              m_d = mag_a;
            end
          end
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end

      CALC: begin
        if (is_div_q) begin
          p_d = div_ge ? div_diff[WIDTH-1:0] : div_rem_sh[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], div_ge};
        end else begin
          p_d = mul_sum[WIDTH:1];
          q_d = {mul_sum[0], q_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == c_last_iter) state_d = SIGN;
      end

      SIGN: begin
        if (div0_q) begin
          hi_d = p_q;
          lo_d = '1;
        end else if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      p_q         <= '0;
      q_q         <= '0;
      m_q         <= '0;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      div0_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      p_q         <= p_d;
      q_q         <= q_d;
      m_q         <= m_d;
      is_div_q    <= is_div_d;
      is_signed_q <= is_signed_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      div0_q      <= div0_d;
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = (state_q != IDLE);
  assign stall       = busy & id_uses_hilo;
  assign pc_write    = ~stall;
  assign if_id_write = ~stall;
  assign bubble      = stall;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
// Module   : tb_muldiv_sequencer
// Brief    : Directed vector bench for muldiv_sequencer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b, wdata;
  logic        hi_we, lo_we, id_uses_hilo;
  logic [31:0] hi, lo;
  logic        busy, stall, pc_write, if_id_write, bubble;

  int checks   = 0;
  int failures = 0;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .id_uses_hilo(id_uses_hilo),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall), .pc_write(pc_write),
    .if_id_write(if_id_write), .bubble(bubble)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!reset && busy && start) begin
      failures++;
      $display("FAIL start_while_busy: start=%0b busy=%0b, required no start while busy", start, busy);
    end
  end

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        uses;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic uses, input logic with_lo_we,
                        input logic [31:0] ehi, input logic [31:0] elo, input int ecyc);
    logic [31:0] hi0, lo0;
    int cyc;
    bit bad_stall, bad_hold;
    @(posedge clock); #1;
    hi0 = hi;
    lo0 = lo;
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    id_uses_hilo = uses; lo_we = with_lo_we; wdata = 32'hDEADBEEF;
    #1;
    check({nm, "_start_nostall"}, {62'd0, stall, pc_write}, 64'h1);
    @(posedge clock); #1;
    start = 1'b0; lo_we = 1'b0;
    cyc = 0; bad_stall = 0; bad_hold = 0;
    while (busy && cyc < 100) begin
      if (stall !== uses || pc_write !== ~uses || if_id_write !== ~uses || bubble !== uses)
        bad_stall = 1;
      if (hi !== hi0 || lo !== lo0) bad_hold = 1;
      cyc++;
      @(posedge clock); #1;
    end
    check({nm, "_busy_cycles"}, 64'(cyc), 64'(ecyc));
    check({nm, "_stall_during_busy"}, {63'd0, bad_stall}, 64'd0);
    check({nm, "_hilo_held"}, {63'd0, bad_hold}, 64'd0);
    check({nm, "_stall_after"}, {61'd0, stall, pc_write, bubble}, 64'h2);
    check({nm, "_hi"}, {32'd0, hi}, {32'd0, ehi});
    check({nm, "_lo"}, {32'd0, lo}, {32'd0, elo});
    id_uses_hilo = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, 33};
    vecs[1] = '{"mult_neg",  2'b00, 32'hFFFFFFFD, 32'h00000007, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB, 33};
    vecs[2] = '{"mult_min2", 2'b00, 32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000, 33};
    vecs[3] = '{"div_neg",   2'b10, 32'hFFFFFFF9, 32'h00000002, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[4] = '{"div_negb",  2'b10, 32'h00000007, 32'hFFFFFFFE, 1'b0, 32'h00000001, 32'hFFFFFFFD, 33};
    vecs[5] = '{"divu",      2'b11, 32'd100,      32'd7,        1'b0, 32'd2,        32'd14,       33};
    vecs[6] = '{"div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000, 33};
    vecs[7] = '{"divu_zero", 2'b11, 32'd5,        32'd0,        1'b1, 32'd5,        32'hFFFFFFFF, 1};
    vecs[8] = '{"div_zero",  2'b10, 32'hFFFFFFFB, 32'd0,        1'b0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1};

    reset = 1'b1; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0; id_uses_hilo = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    check("reset_outs", {59'd0, busy, stall, pc_write, if_id_write, bubble}, 64'h6);
    id_uses_hilo = 1'b0;

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].uses, 1'b0,
             vecs[i].hi, vecs[i].lo, vecs[i].cycles);

    // Idle MTHI / MTLO
    @(posedge clock); #1;
    hi_we = 1'b1; wdata = 32'h1234;
    @(posedge clock); #1;
    hi_we = 1'b0;
    check("mthi", {32'd0, hi}, 64'h1234);
    lo_we = 1'b1; wdata = 32'h5678;
    @(posedge clock); #1;
    lo_we = 1'b0;
    check("mtlo", {32'd0, lo}, 64'h5678);

    // Start together with MTLO: the write is dropped, the product lands
    run_op("start_vs_mtlo", 2'b01, 32'd3, 32'd5, 1'b0, 1'b1, 32'd0, 32'd15, 33);

    // Reset in the middle of a multiply
    @(posedge clock); #1;
    op = 2'b01; operand_a = 32'hFFFFFFFF; operand_b = 32'd3; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1 reset = 1'b1; id_uses_hilo = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("midreset_busy", {63'd0, busy}, 64'd0);
    check("midreset_hilo", {hi, lo}, 64'd0);
    check("midreset_pcw", {63'd0, pc_write}, 64'd1);
    id_uses_hilo = 1'b0;
    run_op("after_reset", 2'b01, 32'd6, 32'd7, 1'b0, 1'b0, 32'd0, 32'd42, 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: simulation time limit reached, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Iterative multiply/divide controller for the pipelined MIPS datapath. It executes MULT/MULTU/DIV/DIVU issued from EX over multiple cycles and owns the HI/LO registers. It services MTHI/MTLO writes. While busy, it stalls the front end whenever the instruction in ID touches HI/LO. Its stall outputs are OR-combined with the load-use hazard stall outside this block.

Parameters:
WIDTH, 32, operand and HI/LO width
CNT_W, 6, iteration counter width (must hold WIDTH)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  EX holds a mult/div this cycle (one-cycle pulse)
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
operand_a  in  WIDTH  rs value (multiplicand / dividend)
operand_b  in  WIDTH  rt value (multiplier / divisor)
hi_we  in  1  MTHI in EX
lo_we  in  1  MTLO in EX
wdata  in  WIDTH  MTHI/MTLO data
id_uses_hilo  in  1  ID instruction is MFHI/MFLO/MTHI/MTLO/MULT*/DIV*
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
busy  out  1  operation in flight
stall  out  1  busy && id_uses_hilo
pc_write  out  1  ~stall
if_id_write  out  1  ~stall
bubble  out  1  stall; selects zero control into ID/EX

Behaviour:
- Reset is synchronous and active-high. All state is updated on the rising edge of clock.
- Reset values: hi=0, lo=0, busy=0, state=IDLE, counter=0. The outputs therefore read stall=0, pc_write=1, if_id_write=1, bubble=0.
- FSM states:
  - IDLE -> CALC on start. Latch the magnitudes of both operands: abs() for signed ops, raw for unsigned. Latch the sign flags, clear the accumulator, set counter=0, set busy=1.
  - CALC: one iteration per cycle. counter increments. Move to SIGN when counter==WIDTH-1 completes.
  - SIGN: apply sign correction, write hi/lo, clear busy, return to IDLE.
- Multiply iteration (shift-add on a 2*WIDTH accumulator {P,Q}, Q initialised to the multiplier magnitude):
  - If Q[0]=1, P=P+multiplicand with a WIDTH+1 bit sum.
  - Then shift {carry,P,Q} right by 1.
- Divide iteration (restoring division):
  - Shift {R,Q} left by 1.
  - If R >= divisor, then R=R-divisor and Q[0]=1.
- Sign fix:
  - Signed mult: if signs differ, negate the 64-bit product.
  - Signed div: quotient is negated if the signs differ; remainder takes the sign of the dividend.
  - Results: mult gives hi=P, lo=Q. Div gives hi=remainder, lo=quotient.
  - -2^31 / -1 yields lo=0x80000000, hi=0.
- Divide by zero: skip CALC and go IDLE -> SIGN. Result is hi=operand_a and lo=0xFFFFFFFF, busy for 1 cycle only.
- Latency: start sampled at edge 0. busy is high for cycles 1..33. hi/lo are updated at the edge that ends the SIGN cycle (edge 33). The result is readable by MFHI/MFLO on the next cycle.
- busy is asserted the cycle after start and drops in the cycle after hi/lo update.
- stall, pc_write, if_id_write and bubble are purely combinational from busy and id_uses_hilo. There is no stall in the start cycle itself.
- start while busy: ignored. It cannot occur if the stall is honoured; the bench asserts this as a checker.
- hi_we/lo_we while IDLE: write wdata at the edge. If asserted together with start, start wins and the writes are dropped.
- hi_we/lo_we while busy: ignored (the stall prevents it).
- hi and lo hold their old values for the whole operation. They are never partially updated.
- reset mid-operation: aborts the operation. hi/lo return to 0 and busy=0 at the next edge.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy for 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. With id_uses_hilo=1 (MFLO) held, stall=1, pc_write=0, bubble=1 for exactly the busy cycles.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100, b=7 -> lo=14, hi=2.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=5, b=0 -> busy 1 cycle, hi=5, lo=0xFFFFFFFF.
- Idle MTHI with wdata=0x1234 -> hi=0x1234 next cycle. Start asserted together with lo_we -> LO write dropped and the product is written.
- Reset asserted at iteration 10 of a MULTU -> next cycle busy=0, hi=lo=0, pc_write=1. A new MULTU 6*7 then gives lo=42, hi=0.
